// File: rtl/sample_pkg.sv
// sample_pkg: shared defaults and midscale helper for sample_tap_buffer
package sample_pkg;
    localparam int DATA_W_DEF = 12;
    localparam int DEPTH_DEF  = 8;

    function automatic logic [31:0] midscale(input int w);
        return 32'(1) << (w - 1);
    endfunction
endpackage

// File: rtl/tap_reg.sv
// tap_reg: one sample register with sync reset, clear and load enable
module tap_reg #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);
    logic [DATA_W-1:0] r_q;

    // reset and clear both return the tap to zero; otherwise load on enable
    always_ff @(posedge clk) begin
        if (i_rst || i_clr)
            r_q <= '0;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/sample_tap_buffer.sv
// sample_tap_buffer: DEPTH-tap sample shift buffer with fill count and frame strobe
// Optional macro SAMPLE_TAP_BUFFER_OFFSET_EN converts offset-binary input to two's complement.
module sample_tap_buffer
    import sample_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         flush,
    input  logic [DATA_W-1:0]            dd,
    output logic [DATA_W-1:0]            qq,
    output logic [DEPTH*DATA_W-1:0]      taps,
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
    output logic                         full,
    output logic                         frame_strobe
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [DATA_W-1:0] w_din;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_fs;

`ifdef SAMPLE_TAP_BUFFER_OFFSET_EN
    localparam logic [DATA_W-1:0] MID = DATA_W'(midscale(DATA_W));
    // subtracting midscale modulo 2^DATA_W is exactly an MSB inversion
    assign w_din = dd - MID;
`else
    assign w_din = dd;
`endif

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_tap
            logic [DATA_W-1:0] w_d;
            if (g == 0) begin : g_head
                assign w_d = w_din;
            end else begin : g_body
                assign w_d = taps[(g-1)*DATA_W +: DATA_W];
            end
            tap_reg #(.DATA_W(DATA_W)) u_tap (
                .clk  (clk),
                .i_rst(reset),
                .i_clr(flush),
                .i_en (enable),
                .i_d  (w_d),
                .o_q  (taps[g*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // fill count advances per accepted sample and saturates at DEPTH
    always_comb begin
        w_cnt_next = r_cnt;
        if (enable && r_cnt != CNT_MAX)
            w_cnt_next = r_cnt + 1'b1;
    end

    // count and strobe register; strobe marks a shift that leaves the buffer full
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_cnt <= '0;
            r_fs  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_fs  <= enable && (w_cnt_next == CNT_MAX);
        end
    end

    assign qq           = taps[DATA_W-1:0];
    assign fill_cnt     = r_cnt;
    assign full         = (r_cnt == CNT_MAX);
    assign frame_strobe = r_fs;
endmodule

// File: tb/tb_sample_tap_buffer.sv
// tb_sample_tap_buffer: directed self-checking bench for sample_tap_buffer
module tb_sample_tap_buffer;
    localparam int DW = 12;
    localparam int DP = 8;

    logic              clk = 1'b0;
    logic              reset, enable, flush;
    logic [DW-1:0]     dd;
    logic [DW-1:0]     qq;
    logic [DP*DW-1:0]  taps;
    logic [3:0]        fill_cnt;
    logic              full, frame_strobe;
    logic [DP*DW-1:0]  saved;
    int                n_cmp = 0;
    int                n_err = 0;

    sample_tap_buffer #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .flush       (flush),
        .dd          (dd),
        .qq          (qq),
        .taps        (taps),
        .fill_cnt    (fill_cnt),
        .full        (full),
        .frame_strobe(frame_strobe)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] conv(input logic [DW-1:0] d);
`ifdef SAMPLE_TAP_BUFFER_OFFSET_EN
        return d ^ 12'h800;
`else
        return d;
`endif
    endfunction

    function automatic logic [DW-1:0] tap(input int k);
        return taps[k*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic fl, input logic [DW-1:0] d);
        reset = r; enable = en; flush = fl; dd = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 1, 0, 12'h5A5);
        chk("rst_qq", qq, 0);
        chk("rst_taps", taps, 0);
        chk("rst_fill", fill_cnt, 0);
        chk("rst_full", full, 0);
        chk("rst_fs", frame_strobe, 0);

        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 0, DW'(i));
            chk("fill_cnt", fill_cnt, i);
            chk("fill_qq", qq, conv(DW'(i)));
            chk("fill_full", full, i == 8);
            chk("fill_fs", frame_strobe, i == 8);
        end
        chk("fill_tap0", tap(0), conv(12'd8));
        chk("fill_tap7", tap(7), conv(12'd1));
        step(0, 0, 0, 12'h3);
        chk("fs_single", frame_strobe, 0);

        step(0, 1, 0, 12'd9);
        chk("sat_tap0", tap(0), conv(12'd9));
        chk("sat_tap7", tap(7), conv(12'd2));
        chk("sat_fill", fill_cnt, 8);
        chk("sat_fs", frame_strobe, 1);
        chk("sat_full", full, 1);

        saved = taps;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, (i % 2) ? 12'hFFF : 12'h000);
            chk("hold_taps", taps, saved);
            chk("hold_qq", qq, conv(12'd9));
            chk("hold_fill", fill_cnt, 8);
            chk("hold_fs", frame_strobe, 0);
        end

        step(0, 0, 1, 0);
        chk("flush_clear", taps, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 0, DW'(16 + i));
        chk("pre_flush_fill", fill_cnt, 5);
        chk("pre_flush_tap4", tap(4), conv(12'd17));
        step(0, 1, 1, 12'h777);
        chk("flush_taps", taps, 0);
        chk("flush_fill", fill_cnt, 0);
        chk("flush_fs", frame_strobe, 0);
        chk("flush_full", full, 0);

        for (int i = 1; i <= 3; i++) step(0, 1, 0, DW'(i));
        chk("pre_rst_fill", fill_cnt, 3);
        step(1, 1, 1, 12'h123);
        chk("midrst_taps", taps, 0);
        chk("midrst_qq", qq, 0);
        chk("midrst_fill", fill_cnt, 0);
        chk("midrst_fs", frame_strobe, 0);
        step(0, 1, 0, 12'hABC);
        chk("post_rst_qq", qq, conv(12'hABC));
        chk("post_rst_fill", fill_cnt, 1);
        chk("post_rst_tap1", tap(1), 0);

`ifdef SAMPLE_TAP_BUFFER_OFFSET_EN
        step(0, 1, 0, 12'h800);
        chk("ofs_800", qq, 12'h000);
        step(0, 1, 0, 12'h000);
        chk("ofs_000", qq, 12'h800);
        step(0, 1, 0, 12'hFFF);
        chk("ofs_fff", qq, 12'h7FF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
